// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam logic [WIDTH_DEF-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_B,
    SUB,
    DONE
  } state_t;

endpackage

// File: rtl/div_rep_sub_if.sv
// Operand/result bundle of the divider; master issues requests, slave is the divider.
interface div_rep_sub_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, data_in,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_datapath.sv
// R/D/Q registers of the divider with subtract/increment step, R>=D compare and Q saturation flag.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             sat_load,
  input  logic             step,
  output logic             r_ge_d_c,
  output logic             q_sat_c,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;

  // sat_load only fires together with load_b and must win over the Q clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      if (load_a) begin
        r_q <= data_in;
      end
      if (load_b) begin
        d_q <= data_in;
        q_q <= '0;
      end
      if (sat_load) begin
        q_q <= '1;
      end
      if (step) begin
        r_q <= r_q - d_q;
        q_q <= q_q + WIDTH'(1);
      end
    end
  end

  assign r_ge_d_c  = (r_q >= d_q);
  assign q_sat_c   = &q_q;
  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/div_rep_sub.sv
// Sequential unsigned divider by repeated subtraction; controller FSM around div_datapath.
// Optional zero-divisor early exit enabled by defining DIV_ZERO_CHECK_EN.
module div_rep_sub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic          clk,
  input logic          rst_n,
  div_rep_sub_if.slave bus
);

  state_t state;
  logic   busy_q;
  logic   done_q;
  logic   dbz_q;

  logic load_a_c;
  logic load_b_c;
  logic zero_c;
  logic step_c;
  logic r_ge_d_c;
  logic q_sat_c;

  assign load_a_c = (state == IDLE) && bus.start;
  assign load_b_c = (state == LOAD_B);
`ifdef DIV_ZERO_CHECK_EN
  assign zero_c   = load_b_c && (bus.data_in == '0);
`else
  assign zero_c   = 1'b0;
`endif
  assign step_c   = (state == SUB) && r_ge_d_c && !q_sat_c;

  div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (bus.data_in),
    .load_a    (load_a_c),
    .load_b    (load_b_c),
    .sat_load  (zero_c),
    .step      (step_c),
    .r_ge_d_c  (r_ge_d_c),
    .q_sat_c   (q_sat_c),
    .quotient  (bus.quotient),
    .remainder (bus.remainder)
  );

  // busy/done are registered from the state being entered, so they line up with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD_B;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
          end
        end
        LOAD_B: begin
          if (zero_c) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dbz_q  <= 1'b1;
          end else begin
            state  <= SUB;
          end
        end
        SUB: begin
          if (!step_c) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule
